// File: rtl/tnn_feature_loader.sv
// tnn_feature_loader: assembles a serial FW-bit feature stream into one
// registered 5-feature frame (a..e) for the TNN classifier core.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_valid/s_ready       input beat handshake
//   s_data, s_last        feature value, end-of-frame marker (5th beat)
//   out_a..out_e          registered frame, stream order (a first)
//   m_valid/m_ready       output frame handshake
//   err_frame             one-cycle pulse on a framing error
//   frame_cnt, err_cnt    saturating 16-bit statistics; present only when
//                         TNN_LOADER_STATS_EN is defined
module tnn_feature_loader #(
    parameter int unsigned FW    = 3,
    parameter int unsigned NFEAT = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [FW-1:0] s_data,
    input  logic          s_last,
    output logic [FW-1:0] out_a,
    output logic [FW-1:0] out_b,
    output logic [FW-1:0] out_c,
    output logic [FW-1:0] out_d,
    output logic [FW-1:0] out_e,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          err_frame
`ifdef TNN_LOADER_STATS_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   err_cnt
`endif
);

    localparam int unsigned IW = 3;
    localparam logic [IW-1:0] LAST_IDX = IW'(NFEAT - 1);

    typedef enum logic [1:0] {FILL, FULL, RESYNC} state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [FW-1:0] shadow [NFEAT];
    logic          beat;
    logic          shadow_we;
    logic          load_direct;
    logic          load_shadow;
    logic          m_valid_next;
    logic          err_next;

    assign beat = s_valid && s_ready;

    // State register; s_ready is registered from the next state so it never
    // depends combinationally on m_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            idx     <= '0;
            s_ready <= 1'b1;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            s_ready <= (state_next != FULL);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        shadow_we    = 1'b0;
        load_direct  = 1'b0;
        load_shadow  = 1'b0;
        err_next     = 1'b0;
        m_valid_next = m_valid && !m_ready;
        case (state)
            FILL: begin
                if (beat) begin
                    shadow_we = 1'b1;
                    if (idx != LAST_IDX) begin
                        if (s_last) begin
                            err_next = 1'b1;
                            idx_next = '0;
                        end else begin
                            idx_next = idx + IW'(1);
                        end
                    end else begin
                        idx_next = '0;
                        if (s_last) begin
                            // Output free or draining: bypass the 5th beat straight in.
                            if (!m_valid || m_ready) begin
                                load_direct  = 1'b1;
                                m_valid_next = 1'b1;
                            end else begin
                                state_next = FULL;
                            end
                        end else begin
                            err_next   = 1'b1;
                            state_next = RESYNC;
                        end
                    end
                end
            end
            FULL: begin
                if (m_ready) begin
                    load_shadow  = 1'b1;
                    m_valid_next = 1'b1;
                    state_next   = FILL;
                end
            end
            RESYNC: begin
                if (beat && s_last) begin
                    state_next = FILL;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = '0;
            end
        endcase
    end

    // Shadow buffer, output registers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NFEAT); i++) shadow[i] <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
            out_e     <= '0;
            m_valid   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            m_valid   <= m_valid_next;
            err_frame <= err_next;
            if (shadow_we) shadow[idx] <= s_data;
            if (load_direct) begin
                out_a <= shadow[0];
                out_b <= shadow[1];
                out_c <= shadow[2];
                out_d <= shadow[3];
                out_e <= s_data;
            end else if (load_shadow) begin
                out_a <= shadow[0];
                out_b <= shadow[1];
                out_c <= shadow[2];
                out_d <= shadow[3];
                out_e <= shadow[4];
            end
        end
    end

`ifdef TNN_LOADER_STATS_EN
    // Saturating frame and error counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (m_valid && m_ready && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (err_next && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Testbench for tnn_feature_loader: beat table plus hand sequences, frames
// checked through a scoreboard queue at each output transfer.
module tb_tnn_feature_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [2:0] s_data;
    logic       s_last;
    logic [2:0] out_a, out_b, out_c, out_d, out_e;
    logic       m_valid;
    logic       m_ready;
    logic       err_frame;
`ifdef TNN_LOADER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    tnn_feature_loader #(.FW(3), .NFEAT(5)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d), .out_e(out_e),
        .m_valid(m_valid), .m_ready(m_ready), .err_frame(err_frame)
`ifdef TNN_LOADER_STATS_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  d;
        logic        l;
        logic        exp_err;
        logic        exp_push;
        logic [14:0] exp_frame;
    } beat_t;

    beat_t       vec[$];
    logic [14:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    int          frames_seen = 0;

    function automatic logic [14:0] fr(input logic [2:0] a, b, c, d, e);
        return {a, b, c, d, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic [2:0] d, input logic l, input logic e,
                       input logic p, input logic [14:0] f);
        beat_t b;
        b.d = d; b.l = l; b.exp_err = e; b.exp_push = p; b.exp_frame = f;
        vec.push_back(b);
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [2:0] d, input logic l);
        bit done = 0;
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!done) begin
            #4;
            if (s_ready) done = 1;
            @(posedge clk);
            if (!done) begin
                n++;
                if (n > 50) begin
                    chk("beat_accept_timeout", 32'd0, 32'd1);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        #4;
    endtask

    // Monitor: sampled 1 time unit before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                if (err_frame) err_seen++;
                if (m_valid && m_ready) begin
                    frames_seen++;
                    if (sb.size() == 0) begin
                        chk("frame_unexpected", {17'd0, out_a, out_b, out_c, out_d, out_e}, 32'd0);
                    end else begin
                        chk("frame_data", {17'd0, out_a, out_b, out_c, out_d, out_e},
                            {17'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        m_ready = 1'b1;
        while ((sb.size() != 0 || m_valid) && n < 100) begin
            sample();
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;

        // Reset state
        sample();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_err", 32'(err_frame), 32'd0);
        chk("rst_out", {17'd0, out_a, out_b, out_c, out_d, out_e}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame, output free: valid the cycle after beat 5 for one cycle
        m_ready = 1'b1;
        sb.push_back(fr(1, 2, 3, 4, 5));
        send_beat(1, 0); send_beat(2, 0); send_beat(3, 0); send_beat(4, 0); send_beat(5, 1);
        idle();
        #4;
        chk("lat_m_valid", 32'(m_valid), 32'd1);
        sample();
        chk("lat_m_valid_drop", 32'(m_valid), 32'd0);

        // Two back-to-back frames with the consumer stalled
        m_ready = 1'b0;
        sb.push_back(fr(1, 2, 3, 4, 5));
        sb.push_back(fr(7, 6, 5, 4, 3));
        send_beat(1, 0); send_beat(2, 0); send_beat(3, 0); send_beat(4, 0); send_beat(5, 1);
        send_beat(7, 0); send_beat(6, 0); send_beat(5, 0); send_beat(4, 0); send_beat(3, 1);
        idle();
        #4;
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        sample();
        chk("stall_hold", {17'd0, out_a, out_b, out_c, out_d, out_e}, {17'd0, fr(1, 2, 3, 4, 5)});
        @(negedge clk);
        m_ready = 1'b1;
        #4;
        sample();
        chk("stall_valid_kept", 32'(m_valid), 32'd1);
        drain("stall_drain");

        // Beat table with m_ready held high
        add(1, 0, 0, 0, 0); add(2, 0, 0, 0, 0); add(3, 1, 1, 0, 0);
        add(2, 0, 0, 0, 0); add(2, 0, 0, 0, 0); add(2, 0, 0, 0, 0); add(2, 0, 0, 0, 0);
        add(2, 1, 0, 1, fr(2, 2, 2, 2, 2));
        add(1, 0, 0, 0, 0); add(2, 0, 0, 0, 0); add(3, 0, 0, 0, 0); add(4, 0, 0, 0, 0);
        add(5, 0, 1, 0, 0);
        add(6, 0, 0, 0, 0); add(7, 0, 0, 0, 0); add(0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0); add(1, 0, 0, 0, 0); add(2, 0, 0, 0, 0); add(3, 0, 0, 0, 0);
        add(4, 1, 0, 1, fr(0, 1, 2, 3, 4));
        add(7, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(7, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
        add(7, 1, 0, 1, fr(7, 0, 7, 0, 7));
        m_ready = 1'b1;
        foreach (vec[i]) begin
            if (vec[i].exp_push) sb.push_back(vec[i].exp_frame);
            if (vec[i].exp_err) err_exp++;
            send_beat(vec[i].d, vec[i].l);
        end
        idle();
        drain("table_drain");
        sample();
        chk("err_pulses", 32'(err_seen), 32'(err_exp));
`ifdef TNN_LOADER_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(frames_seen));
        chk("err_cnt", 32'(err_cnt), 32'(err_exp));
`endif

        // Reset mid-frame discards the partial frame
        m_ready = 1'b0;
        send_beat(1, 0); send_beat(2, 0); send_beat(3, 0);
        idle();
        rst = 1'b1;
        #4;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        sb.push_back(fr(6, 5, 4, 3, 2));
        send_beat(6, 0); send_beat(5, 0); send_beat(4, 0); send_beat(3, 0); send_beat(2, 1);
        idle();
        drain("final_drain");
        chk("final_err_pulses", 32'(err_seen), 32'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
